// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD command-path sequencer.
// Holds the FSM state encoding, response-type codes, interrupt status bit
// positions and the field layout of the command register.
package sd_cmd_pkg;

   localparam int CMD_REG_SIZE  = 14;
   localparam int INT_CMD_SIZE  = 5;
   localparam int CMD_TIMEOUT_W = 16;
   localparam int PHY_CMD_W     = 40;
   localparam int PHY_RESP_W    = 120;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SETUP     = 2'd1,
      EXECUTE   = 2'd2,
      BUSY_WAIT = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      RESP_NONE       = 2'b00,
      RESP_SHORT      = 2'b01,
      RESP_LONG       = 2'b10,
      RESP_SHORT_BUSY = 2'b11
   } resp_type_t;

   // Bit positions inside int_status_o.
   localparam int INT_CC    = 0;
   localparam int INT_EI    = 1;
   localparam int INT_CTE   = 2;
   localparam int INT_CCRCE = 3;
   localparam int INT_CIE   = 4;

   // Field positions inside command_i.
   localparam int CMD_RESP_LSB = 0;
   localparam int CMD_RESP_MSB = 1;
   localparam int CMD_CRC_CHK  = 3;
   localparam int CMD_IDX_CHK  = 4;
   localparam int CMD_IDX_LSB  = 8;
   localparam int CMD_IDX_MSB  = 13;

   // PHY setting: [0] a response is expected, [1] the response is long.
   function automatic logic [1:0] phy_setting(input resp_type_t t);
      return {t == RESP_LONG, t != RESP_NONE};
   endfunction

endpackage

// File: rtl/sd_cmd_sequencer_if.sv
// Bus between the command sequencer and the serial command PHY.
// master = sequencer side, slave = PHY side.
interface sd_cmd_sequencer_if;
   import sd_cmd_pkg::*;

   logic [PHY_CMD_W-1:0]  cmd;
   logic                  start;
   logic [1:0]            setting;
   logic                  abort;
   logic                  finish;
   logic                  crc_ok;
   logic                  index_ok;
   logic [PHY_RESP_W-1:0] resp;

   modport master (
      output cmd, start, setting, abort,
      input  finish, crc_ok, index_ok, resp
   );

   modport slave (
      input  cmd, start, setting, abort,
      output finish, crc_ok, index_ok, resp
   );

endinterface

// File: rtl/sd_cmd_timeout_cnt.sv
// Loadable saturating cycle counter for the command timeout.
// hit is high while the count equals limit-1; a zero limit never hits.
module sd_cmd_timeout_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic         hit
);

   logic [W-1:0] count_q;

   // Count enabled cycles, stopping at all-ones instead of wrapping.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (en && (count_q != '1)) begin
         count_q <= count_q + W'(1);
      end
   end

   assign hit = (limit != '0) && (count_q == (limit - W'(1)));

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SD command-path sequencer: takes a command from the register file, drives
// the serial command PHY, captures the response and raises sticky status.
// Optional build macro SD_CMD_RETRY_EN: reissue a command that failed its
// CRC or index check, up to MAX_RETRIES times, before reporting the error.
module sd_cmd_sequencer
   import sd_cmd_pkg::*;
#(
   parameter int MAX_RETRIES = 2
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic                     soft_rst_i,
   input  logic                     start_i,
   input  logic [CMD_REG_SIZE-1:0]  command_i,
   input  logic [31:0]              argument_i,
   input  logic [CMD_TIMEOUT_W-1:0] timeout_i,
   input  logic                     int_rst_i,
   sd_cmd_sequencer_if.master       phy,
   input  logic                     dat0_busy_i,
   output logic [31:0]              response_0_o,
   output logic [31:0]              response_1_o,
   output logic [31:0]              response_2_o,
   output logic [31:0]              response_3_o,
   output logic [INT_CMD_SIZE-1:0]  int_status_o,
   output logic                     busy_o
);

   state_t                   state_q, next_state;
   resp_type_t               resp_type_q;
   logic                     crc_chk_q, idx_chk_q;
   logic [5:0]               index_q;
   logic [31:0]              arg_q;
   logic [CMD_TIMEOUT_W-1:0] timeout_q;

   logic                     latch_cmd, issue, abort_req, load_resp;
   logic                     count_en, to_hit, crc_err, idx_err, retry_ok;
   logic [INT_CMD_SIZE-1:0]  status_set;

   // Reserved command register bits carry no meaning for this block.
   logic unused_cmd_bits;
   assign unused_cmd_bits = ^{command_i[7:5], command_i[2]};

   assign crc_err  = crc_chk_q & ~phy.crc_ok;
   assign idx_err  = idx_chk_q & ~phy.index_ok;
   assign busy_o   = (state_q != IDLE);
   assign count_en = (state_q == EXECUTE) || (state_q == BUSY_WAIT);

   sd_cmd_timeout_cnt #(
      .W (CMD_TIMEOUT_W)
   ) u_timeout (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .clear (soft_rst_i | issue),
      .en    (count_en),
      .limit (timeout_q),
      .hit   (to_hit)
   );

`ifdef SD_CMD_RETRY_EN
   localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
   logic [RETRY_W-1:0] retry_q;

   assign retry_ok = (int'(retry_q) < MAX_RETRIES);

   // Count reissues of the current command; an accepted start rearms the budget.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         retry_q <= '0;
      end else if (soft_rst_i || latch_cmd) begin
         retry_q <= '0;
      end else if ((state_q == EXECUTE) && (next_state == SETUP)) begin
         retry_q <= retry_q + RETRY_W'(1);
      end
   end
`else
   // Without retries the limit is irrelevant; errors report at once.
   localparam int unused_max_retries = MAX_RETRIES;
   assign retry_ok = 1'b0;
`endif

   // State register; soft reset returns to IDLE synchronously.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
      end else if (soft_rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= next_state;
      end
   end

   // Next-state and per-cycle action decode.
   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      next_state = state_q;
      latch_cmd  = 1'b0;
      issue      = 1'b0;
      abort_req  = 1'b0;
      load_resp  = 1'b0;
      status_set = '0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               latch_cmd  = 1'b1;
               next_state = SETUP;
            end
         end
         SETUP: begin
            issue      = 1'b1;
            next_state = EXECUTE;
         end
         EXECUTE: begin
            // A finish in the timeout cycle takes priority over the timeout.
            if (phy.finish) begin
               if (crc_err || idx_err) begin
                  if (retry_ok) begin
                     next_state = SETUP;
                  end else begin
                     status_set[INT_EI]    = 1'b1;
                     status_set[INT_CCRCE] = crc_err;
                     status_set[INT_CIE]   = idx_err;
                     next_state            = IDLE;
                  end
               end else begin
                  load_resp = 1'b1;
                  if (resp_type_q == RESP_SHORT_BUSY) begin
                     next_state = BUSY_WAIT;
                  end else begin
                     status_set[INT_CC] = 1'b1;
                     next_state         = IDLE;
                  end
               end
            end else if (to_hit) begin
               status_set[INT_CTE] = 1'b1;
               status_set[INT_EI]  = 1'b1;
               abort_req           = 1'b1;
               next_state          = IDLE;
            end
         end
         BUSY_WAIT: begin
            if (!dat0_busy_i) begin
               status_set[INT_CC] = 1'b1;
               next_state         = IDLE;
            end else if (to_hit) begin
               status_set[INT_CTE] = 1'b1;
               status_set[INT_EI]  = 1'b1;
               abort_req           = 1'b1;
               next_state          = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Capture the command on an accepted start so later register writes cannot disturb it.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         resp_type_q <= RESP_NONE;
         crc_chk_q   <= 1'b0;
         idx_chk_q   <= 1'b0;
         index_q     <= '0;
         arg_q       <= '0;
         timeout_q   <= '0;
      end else if (soft_rst_i) begin
         resp_type_q <= RESP_NONE;
         crc_chk_q   <= 1'b0;
         idx_chk_q   <= 1'b0;
         index_q     <= '0;
         arg_q       <= '0;
         timeout_q   <= '0;
      end else if (latch_cmd) begin
         resp_type_q <= resp_type_t'(command_i[CMD_RESP_MSB:CMD_RESP_LSB]);
         crc_chk_q   <= command_i[CMD_CRC_CHK];
         idx_chk_q   <= command_i[CMD_IDX_CHK];
         index_q     <= command_i[CMD_IDX_MSB:CMD_IDX_LSB];
         arg_q       <= argument_i;
         timeout_q   <= timeout_i;
      end
   end

   // Registered outputs: PHY strobes, response registers and sticky status.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         phy.cmd      <= '0;
         phy.start    <= 1'b0;
         phy.setting  <= '0;
         phy.abort    <= 1'b0;
         response_0_o <= '0;
         response_1_o <= '0;
         response_2_o <= '0;
         response_3_o <= '0;
         int_status_o <= '0;
      end else if (soft_rst_i) begin
         phy.cmd      <= '0;
         phy.start    <= 1'b0;
         phy.setting  <= '0;
         // Tell the PHY to drop an in-flight transfer; busy_o is low again next cycle.
         phy.abort    <= busy_o;
         response_0_o <= '0;
         response_1_o <= '0;
         response_2_o <= '0;
         response_3_o <= '0;
         int_status_o <= '0;
      end else begin
         phy.start <= issue;
         phy.abort <= abort_req;
         if (issue) begin
            phy.cmd     <= {2'b01, index_q, arg_q};
            phy.setting <= phy_setting(resp_type_q);
         end
         if (load_resp) begin
            case (resp_type_q)
               RESP_SHORT, RESP_SHORT_BUSY: begin
                  response_0_o <= phy.resp[119:88];
               end
               RESP_LONG: begin
                  response_0_o <= phy.resp[119:88];
                  response_1_o <= phy.resp[87:56];
                  response_2_o <= phy.resp[55:24];
                  response_3_o <= {phy.resp[23:0], 8'h00};
               end
               default: ;
            endcase
         end
         // A new event wins over a simultaneous clear.
         int_status_o <= (int_rst_i ? '0 : int_status_o) | status_set;
      end
   end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Self-checking bench for sd_cmd_sequencer. The bench plays the PHY; expected
// transfers and completions are queued when a command is issued and compared
// by monitors when the DUT strobes phy.start or drops busy_o.
module tb_sd_cmd_sequencer;
   import sd_cmd_pkg::*;

   logic                     wb_clk_i = 1'b0;
   logic                     wb_rst_i = 1'b0;
   logic                     soft_rst_i = 1'b0;
   logic                     start_i = 1'b0;
   logic [CMD_REG_SIZE-1:0]  command_i = '0;
   logic [31:0]              argument_i = '0;
   logic [CMD_TIMEOUT_W-1:0] timeout_i = '0;
   logic                     int_rst_i = 1'b0;
   logic                     dat0_busy_i = 1'b0;
   logic [31:0]              response_0_o, response_1_o, response_2_o, response_3_o;
   logic [INT_CMD_SIZE-1:0]  int_status_o;
   logic                     busy_o;

   sd_cmd_sequencer_if phy ();

   sd_cmd_sequencer dut (
      .wb_clk_i     (wb_clk_i),
      .wb_rst_i     (wb_rst_i),
      .soft_rst_i   (soft_rst_i),
      .start_i      (start_i),
      .command_i    (command_i),
      .argument_i   (argument_i),
      .timeout_i    (timeout_i),
      .int_rst_i    (int_rst_i),
      .phy          (phy),
      .dat0_busy_i  (dat0_busy_i),
      .response_0_o (response_0_o),
      .response_1_o (response_1_o),
      .response_2_o (response_2_o),
      .response_3_o (response_3_o),
      .int_status_o (int_status_o),
      .busy_o       (busy_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

`ifdef SD_CMD_RETRY_EN
   localparam int TRIES = 3;
`else
   localparam int TRIES = 1;
`endif

   typedef struct packed {
      logic [39:0] cmd;
      logic [1:0]  setting;
   } exp_issue_t;

   typedef struct packed {
      logic [31:0] r0, r1, r2, r3;
      logic [4:0]  status;
   } exp_done_t;

   exp_issue_t  issue_q[$];
   exp_done_t   done_q[$];
   logic [31:0] mr0 = '0, mr1 = '0, mr2 = '0, mr3 = '0;
   logic        sb_on = 1'b1;
   int          n_checks = 0;
   int          n_fail = 0;

   function automatic logic [1:0] exp_setting(input logic [1:0] t);
      case (t)
         2'b00:   return 2'b00;
         2'b10:   return 2'b11;
         default: return 2'b01;
      endcase
   endfunction

   // Monitors: compare each PHY strobe and each completion against the queues.
   initial begin
      exp_issue_t ei;
      exp_done_t  ed;
      logic       busy_d;
      busy_d = 1'b0;
      forever begin
         @(negedge wb_clk_i);
         if (phy.start === 1'b1) begin
            n_checks++;
            if (issue_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_phy_start: got cmd=%h, required no transfer", phy.cmd);
            end else begin
               ei = issue_q.pop_front();
               if ({phy.cmd, phy.setting} !== {ei.cmd, ei.setting}) begin
                  n_fail++;
                  $display("FAIL phy_issue: got cmd=%h set=%b, required cmd=%h set=%b",
                           phy.cmd, phy.setting, ei.cmd, ei.setting);
               end
            end
         end
         if (sb_on && busy_d && !busy_o) begin
            n_checks++;
            if (done_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_completion: got status=%h, required none", int_status_o);
            end else begin
               ed = done_q.pop_front();
               if ({response_0_o, response_1_o, response_2_o, response_3_o, int_status_o} !==
                   {ed.r0, ed.r1, ed.r2, ed.r3, ed.status}) begin
                  n_fail++;
                  $display("FAIL completion: got r=%h_%h_%h_%h st=%h, required r=%h_%h_%h_%h st=%h",
                           response_0_o, response_1_o, response_2_o, response_3_o, int_status_o,
                           ed.r0, ed.r1, ed.r2, ed.r3, ed.status);
               end
            end
         end
         busy_d = busy_o;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, required finish within 200000 ns");
      $fatal(1, "watchdog");
   end

   // Called at a negedge. Queues the expected transfer(s), pulses start_i and
   // returns the number of cycles until phy.start is seen (-1 if never).
   task automatic issue_cmd(input logic [13:0] cmd, input logic [31:0] arg,
                            input logic [CMD_TIMEOUT_W-1:0] tmo, input int tries, output int lat);
      for (int i = 0; i < tries; i++)
         issue_q.push_back('{cmd: {2'b01, cmd[13:8], arg}, setting: exp_setting(cmd[1:0])});
      command_i  = cmd;
      argument_i = arg;
      timeout_i  = tmo;
      start_i    = 1'b1;
      lat        = -1;
      for (int c = 1; c <= 50; c++) begin
         @(negedge wb_clk_i);
         start_i = 1'b0;
         if (phy.start === 1'b1) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic phy_finish(input logic crc_ok, input logic idx_ok, input logic [119:0] resp);
      phy.finish   = 1'b1;
      phy.crc_ok   = crc_ok;
      phy.index_ok = idx_ok;
      phy.resp     = resp;
      @(negedge wb_clk_i);
      phy.finish   = 1'b0;
      phy.crc_ok   = 1'b0;
      phy.index_ok = 1'b0;
   endtask

   task automatic clear_int();
      int_rst_i = 1'b1;
      @(negedge wb_clk_i);
      int_rst_i = 1'b0;
   endtask

   task automatic push_done(input logic [4:0] status);
      done_q.push_back('{r0: mr0, r1: mr1, r2: mr2, r3: mr3, status: status});
   endtask

   task automatic test_reset();
      #2 wb_rst_i = 1'b1;
      #1;
      n_checks += 4;
      if (busy_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy: got %b, required 0", busy_o);
      end
      if (int_status_o !== 5'h00) begin
         n_fail++; $display("FAIL reset_status: got %h, required 00", int_status_o);
      end
      if ({response_0_o, response_1_o, response_2_o, response_3_o} !== 128'h0) begin
         n_fail++; $display("FAIL reset_responses: got %h_%h_%h_%h, required 0",
                            response_0_o, response_1_o, response_2_o, response_3_o);
      end
      if ({phy.cmd, phy.start, phy.setting, phy.abort} !== 44'h0) begin
         n_fail++; $display("FAIL reset_phy: got cmd=%h st=%b set=%b ab=%b, required 0",
                            phy.cmd, phy.start, phy.setting, phy.abort);
      end
      repeat (2) @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);
   endtask

   task automatic test_short();
      int lat;
      mr0 = 32'h000001AA;
      push_done(5'h01);
      issue_cmd(14'h0801, 32'h000001AA, '0, 1, lat);
      n_checks += 3;
      if (lat !== 2) begin
         n_fail++; $display("FAIL start_latency: got %0d, required 2", lat);
      end
      if (phy.cmd !== 40'h48000001AA) begin
         n_fail++; $display("FAIL short_phy_cmd: got %h, required 48000001aa", phy.cmd);
      end
      if (busy_o !== 1'b1) begin
         n_fail++; $display("FAIL short_busy: got %b, required 1", busy_o);
      end
      repeat (3) @(negedge wb_clk_i);
      phy_finish(1'b1, 1'b1, {32'h000001AA, 88'h55AA55AA55AA55AA55AA55});
      n_checks += 2;
      if (int_status_o !== 5'h01) begin
         n_fail++; $display("FAIL short_cc: got %h, required 01", int_status_o);
      end
      if (response_0_o !== 32'h000001AA) begin
         n_fail++; $display("FAIL short_r0: got %h, required 000001aa", response_0_o);
      end
      clear_int();
      n_checks++;
      if (int_status_o !== 5'h00) begin
         n_fail++; $display("FAIL int_rst_clear: got %h, required 00", int_status_o);
      end
   endtask

   task automatic test_long();
      int lat;
      mr0 = 32'h01020304; mr1 = 32'h05060708; mr2 = 32'h090A0B0C; mr3 = 32'h0D0E0F00;
      push_done(5'h01);
      issue_cmd(14'h0202, 32'h00000000, '0, 1, lat);
      repeat (2) @(negedge wb_clk_i);
      phy_finish(1'b1, 1'b1, 120'h0102030405060708090A0B0C0D0E0F);
      n_checks += 2;
      if (response_3_o[7:0] !== 8'h00) begin
         n_fail++; $display("FAIL long_r3_pad: got %h, required 00", response_3_o[7:0]);
      end
      if (response_2_o !== 32'h090A0B0C) begin
         n_fail++; $display("FAIL long_r2: got %h, required 090a0b0c", response_2_o);
      end
      clear_int();
   endtask

   task automatic test_no_resp();
      int lat;
      push_done(5'h01);
      issue_cmd(14'h0000, 32'h00000000, '0, 1, lat);
      repeat (2) @(negedge wb_clk_i);
      phy_finish(1'b1, 1'b1, {120{1'b1}});
      n_checks++;
      if (response_0_o !== 32'h01020304) begin
         n_fail++; $display("FAIL none_keeps_r0: got %h, required 01020304", response_0_o);
      end
      clear_int();
   endtask

   task automatic test_timeout();
      int lat, cyc;
      push_done(5'h06);
      issue_cmd(14'h0D01, 32'h00010000, 16, 1, lat);
      cyc = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge wb_clk_i);
         if (phy.abort === 1'b1) begin
            cyc = c;
            break;
         end
      end
      n_checks += 3;
      if (cyc !== 16) begin
         n_fail++; $display("FAIL timeout_abort_cycle: got %0d, required 16", cyc);
      end
      if (int_status_o !== 5'h06) begin
         n_fail++; $display("FAIL timeout_status: got %h, required 06", int_status_o);
      end
      if (busy_o !== 1'b0) begin
         n_fail++; $display("FAIL timeout_idle: got busy %b, required 0", busy_o);
      end
      @(negedge wb_clk_i);
      n_checks++;
      if (phy.abort !== 1'b0) begin
         n_fail++; $display("FAIL timeout_abort_pulse: got %b, required 0", phy.abort);
      end
      clear_int();
      n_checks++;
      if (int_status_o !== 5'h00) begin
         n_fail++; $display("FAIL timeout_int_rst: got %h, required 00", int_status_o);
      end
   endtask

   // Finish in the very cycle the timeout would fire: completion must win.
   task automatic test_finish_wins();
      int lat;
      mr0 = 32'hCAFEF00D;
      push_done(5'h01);
      issue_cmd(14'h0D01, 32'h00020000, 4, 1, lat);
      repeat (3) @(negedge wb_clk_i);
      phy_finish(1'b1, 1'b1, {32'hCAFEF00D, 88'h0});
      n_checks += 2;
      if (int_status_o !== 5'h01) begin
         n_fail++; $display("FAIL finish_wins_status: got %h, required 01", int_status_o);
      end
      if (phy.abort !== 1'b0) begin
         n_fail++; $display("FAIL finish_wins_abort: got %b, required 0", phy.abort);
      end
      clear_int();
   endtask

   task automatic test_cmd_errors();
      logic [13:0] cmds[2]  = '{14'h1119, 14'h0911};
      logic        crcs[2]  = '{1'b0, 1'b1};
      logic        idxs[2]  = '{1'b1, 1'b0};
      logic [4:0]  stats[2] = '{5'h0A, 5'h12};
      int lat;
      logic ok;
      for (int k = 0; k < 2; k++) begin
         push_done(stats[k]);
         issue_cmd(cmds[k], 32'h12345678 + 32'(k), '0, TRIES, lat);
         for (int t = 0; t < TRIES; t++) begin
            if (t > 0) begin
               ok = 1'b0;
               for (int c = 0; c < 20; c++) begin
                  @(negedge wb_clk_i);
                  if (phy.start === 1'b1) begin
                     ok = 1'b1;
                     break;
                  end
               end
               n_checks++;
               if (!ok) begin
                  n_fail++; $display("FAIL retry_reissue: got no phy_start, required attempt %0d", t + 1);
               end
            end
            repeat (2) @(negedge wb_clk_i);
            phy_finish(crcs[k], idxs[k], {120{1'b1}});
            if (t < TRIES - 1) begin
               n_checks++;
               if (int_status_o !== 5'h00) begin
                  n_fail++; $display("FAIL retry_early_status: got %h, required 00", int_status_o);
               end
            end
         end
         n_checks += 2;
         if (int_status_o !== stats[k]) begin
            n_fail++; $display("FAIL error_status: got %h, required %h", int_status_o, stats[k]);
         end
         if (response_0_o !== mr0) begin
            n_fail++; $display("FAIL error_keeps_r0: got %h, required %h", response_0_o, mr0);
         end
         clear_int();
      end
   endtask

   task automatic test_busy_wait();
      int lat, starts;
      dat0_busy_i = 1'b1;
      mr0 = 32'h00000900;
      push_done(5'h01);
      issue_cmd(14'h0703, 32'h00010000, '0, 1, lat);
      repeat (2) @(negedge wb_clk_i);
      phy_finish(1'b1, 1'b1, {32'h00000900, 88'h0});
      starts = 0;
      for (int c = 0; c < 20; c++) begin
         start_i   = (c == 5);
         command_i = 14'h0801;
         @(negedge wb_clk_i);
         if (phy.start === 1'b1) starts++;
      end
      start_i = 1'b0;
      n_checks += 4;
      if (int_status_o !== 5'h00) begin
         n_fail++; $display("FAIL busy_no_cc_yet: got %h, required 00", int_status_o);
      end
      if (busy_o !== 1'b1) begin
         n_fail++; $display("FAIL busy_still_busy: got %b, required 1", busy_o);
      end
      if (starts !== 0) begin
         n_fail++; $display("FAIL busy_start_ignored: got %0d strobes, required 0", starts);
      end
      if (response_0_o !== 32'h00000900) begin
         n_fail++; $display("FAIL busy_r0: got %h, required 00000900", response_0_o);
      end
      dat0_busy_i = 1'b0;
      @(negedge wb_clk_i);
      n_checks++;
      if (int_status_o !== 5'h01) begin
         n_fail++; $display("FAIL busy_cc_after_release: got %h, required 01", int_status_o);
      end
      clear_int();
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [127:0] rnd;
      logic [31:0]  arg;
      for (int i = 0; i < 4; i++) begin
         rnd = {$urandom, $urandom, $urandom, $urandom};
         arg = $urandom;
         mr0 = rnd[119:88];
         push_done(5'h01);
         issue_cmd({6'(20 + i), 8'h01}, arg, '0, 1, lat);
         n_checks++;
         if (lat !== 2) begin
            n_fail++; $display("FAIL b2b_latency: got %0d, required 2", lat);
         end
         @(negedge wb_clk_i);
         phy_finish(1'b1, 1'b1, rnd[119:0]);
      end
   endtask

   task automatic test_soft_reset();
      int lat;
      sb_on = 1'b0;
      issue_cmd(14'h0801, 32'h0000BEEF, '0, 1, lat);
      repeat (4) @(negedge wb_clk_i);
      soft_rst_i = 1'b1;
      @(negedge wb_clk_i);
      n_checks += 4;
      if (phy.abort !== 1'b1) begin
         n_fail++; $display("FAIL soft_abort: got %b, required 1", phy.abort);
      end
      if (busy_o !== 1'b0) begin
         n_fail++; $display("FAIL soft_busy: got %b, required 0", busy_o);
      end
      if (int_status_o !== 5'h00) begin
         n_fail++; $display("FAIL soft_status: got %h, required 00", int_status_o);
      end
      if ({response_0_o, response_1_o, response_2_o, response_3_o} !== 128'h0) begin
         n_fail++; $display("FAIL soft_responses: got %h_%h_%h_%h, required 0",
                            response_0_o, response_1_o, response_2_o, response_3_o);
      end
      @(negedge wb_clk_i);
      n_checks++;
      if (phy.abort !== 1'b0) begin
         n_fail++; $display("FAIL soft_abort_once: got %b, required 0", phy.abort);
      end
      soft_rst_i = 1'b0;
      mr0 = '0; mr1 = '0; mr2 = '0; mr3 = '0;
      @(negedge wb_clk_i);
      sb_on = 1'b1;
   endtask

   task automatic test_async_reset();
      int lat;
      mr0 = 32'h00ABCDEF;
      push_done(5'h01);
      issue_cmd(14'h0801, 32'h00000001, '0, 1, lat);
      @(negedge wb_clk_i);
      phy_finish(1'b1, 1'b1, {32'h00ABCDEF, 88'h0});
      sb_on = 1'b0;
      issue_cmd(14'h0801, 32'h00000002, '0, 1, lat);
      repeat (3) @(negedge wb_clk_i);
      #2 wb_rst_i = 1'b1;
      #1;
      n_checks += 3;
      if (busy_o !== 1'b0) begin
         n_fail++; $display("FAIL async_busy: got %b, required 0", busy_o);
      end
      if ({response_0_o, int_status_o} !== 37'h0) begin
         n_fail++; $display("FAIL async_regs: got r0=%h st=%h, required 0", response_0_o, int_status_o);
      end
      if (phy.cmd !== 40'h0) begin
         n_fail++; $display("FAIL async_phy_cmd: got %h, required 0", phy.cmd);
      end
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      mr0 = '0; mr1 = '0; mr2 = '0; mr3 = '0;
      @(negedge wb_clk_i);
      sb_on = 1'b1;
   endtask

   initial begin
      phy.finish   = 1'b0;
      phy.crc_ok   = 1'b0;
      phy.index_ok = 1'b0;
      phy.resp     = '0;
      test_reset();
      test_short();
      test_long();
      test_no_resp();
      test_timeout();
      test_finish_wins();
      test_cmd_errors();
      test_busy_wait();
      test_back_to_back();
      test_soft_reset();
      test_async_reset();
      repeat (3) @(negedge wb_clk_i);
      n_checks += 2;
      if (issue_q.size() != 0) begin
         n_fail++; $display("FAIL issue_queue_drained: got %0d left, required 0", issue_q.size());
      end
      if (done_q.size() != 0) begin
         n_fail++; $display("FAIL done_queue_drained: got %0d left, required 0", done_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
